// File: rtl/serial_load_tx.sv
// 4-bit parallel-in, serial-out transmitter: captures bit3..bit0 on load,
// then shifts them out LSB-first on tx, pulsing finish with the last bit.
module serial_load_tx (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       bit0,
  input  logic       bit1,
  input  logic       bit2,
  input  logic       bit3,
  output logic       tx,
  output logic       finish,
  output logic [2:0] count,
  output logic [3:0] sender
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;
  localparam logic [2:0] WORD_BITS = 3'd4;

  logic [0:0] state;
  logic [2:0] count_inc;
  logic       last_bit;

  assign count_inc = count + 3'd1;
  assign last_bit  = (count_inc == WORD_BITS);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      sender <= 4'b0000;
      count  <= 3'd0;
      tx     <= 1'b1;
      finish <= 1'b0;
    end else if (load) begin
      // Load wins in every state, so a load mid-word aborts it silently.
      state  <= SHIFT;
      sender <= {bit3, bit2, bit1, bit0};
      count  <= 3'd0;
      tx     <= 1'b1;
      finish <= 1'b0;
    end else begin
      case (state)
        SHIFT: begin
          tx     <= sender[0];
          sender <= {1'b0, sender[3:1]};
          count  <= count_inc;
          finish <= last_bit;
          if (last_bit) state <= IDLE;
        end
        default: begin
          // count and sender hold, leaving 4 / 0000 visible after a word.
          tx     <= 1'b1;
          finish <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_load_tx.sv
// Directed and randomized checks of serial_load_tx against a queue-based
// model of the bits still waiting to go out on tx.
module tb_serial_load_tx;
  logic       clk = 1'b0;
  logic       reset, load, bit0, bit1, bit2, bit3;
  logic       tx, finish;
  logic [2:0] count;
  logic [3:0] sender;

  serial_load_tx dut (
    .clk(clk), .reset(reset), .load(load),
    .bit0(bit0), .bit1(bit1), .bit2(bit2), .bit3(bit3),
    .tx(tx), .finish(finish), .count(count), .sender(sender)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  int   fin_seen = 0;
  bit   q[$];
  int   sent;
  logic m_tx, m_fin;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    sent  = 0;
    m_tx  = 1'b1;
    m_fin = 1'b0;
  endtask

  // Word = bits still queued; sent = bits put on the wire since load.
  task automatic model_edge();
    if (load) begin
      q = '{bit0, bit1, bit2, bit3};
      sent  = 0;
      m_tx  = 1'b1;
      m_fin = 1'b0;
    end else if (q.size() > 0) begin
      m_tx  = q.pop_front();
      sent++;
      m_fin = (q.size() == 0);
    end else begin
      m_tx  = 1'b1;
      m_fin = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    logic [3:0] s;
    s = 4'b0000;
    foreach (q[i]) s[i] = q[i];
    chk({tag, ".tx"},     {3'b0, tx},     {3'b0, m_tx});
    chk({tag, ".finish"}, {3'b0, finish}, {3'b0, m_fin});
    chk({tag, ".count"},  {1'b0, count},  4'(sent));
    chk({tag, ".sender"}, sender,         s);
  endtask

  task automatic drive(input logic ld, input logic [3:0] d);
    load = ld;
    {bit3, bit2, bit1, bit0} = d;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    if (!reset) model_reset(); else model_edge();
    #1;
    fin_seen += int'(finish);
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    reset = 1'b0;
    model_reset();
    #1;
    check_all(tag);
  endtask

  initial begin
    int f0;
    logic [3:0] d;

    // Reset: asynchronous, then held across two edges with random inputs.
    reset = 1'b1;
    drive(1'($urandom), 4'($urandom));
    #1;
    async_reset("rst_async");
    for (int i = 0; i < 2; i++) begin
      drive(1'($urandom), 4'($urandom));
      step($sformatf("rst_hold%0d", i));
    end
    drive(1'b0, 4'($urandom));
    reset = 1'b1;
    step("rst_idle");

    // Basic word 0101, expected tx 1,0,1,0.
    drive(1'b1, 4'b0101);
    step("basic_L");
    for (int i = 1; i <= 5; i++) begin
      drive(1'b0, 4'($urandom));
      step($sformatf("basic_L%0d", i));
    end
    chk("basic_end_sender", sender, 4'b0000);

    // Held load with changing data.
    drive(1'b1, 4'b0000); step("held0");
    drive(1'b1, 4'($urandom)); step("held1");
    drive(1'b1, 4'b1111); step("held2");
    for (int i = 1; i <= 5; i++) begin
      drive(1'b0, 4'($urandom));
      step($sformatf("held_L%0d", i));
    end

    // Abort at count=2 with a new word; only the second word finishes.
    f0 = fin_seen;
    drive(1'b1, 4'b1010); step("abort_L");
    drive(1'b0, 4'($urandom)); step("abort_L1");
    drive(1'b0, 4'($urandom)); step("abort_L2");
    drive(1'b1, 4'b0011); step("abort_reload");
    for (int i = 1; i <= 5; i++) begin
      drive(1'b0, 4'($urandom));
      step($sformatf("abort_M%0d", i));
    end
    chk("abort_finish_pulses", 4'(fin_seen - f0), 4'd1);

    // Reset in the middle of a word.
    f0 = fin_seen;
    drive(1'b1, 4'($urandom)); step("mrst_L");
    drive(1'b0, 4'($urandom)); step("mrst_L1");
    drive(1'b0, 4'($urandom)); step("mrst_L2");
    async_reset("mrst_async");
    step("mrst_hold");
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'($urandom));
      step($sformatf("mrst_idle%0d", i));
    end
    chk("mrst_finish_pulses", 4'(fin_seen - f0), 4'd0);

    // Back-to-back words, reload on L+5.
    f0 = fin_seen;
    drive(1'b1, 4'($urandom)); step("b2b_L");
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 4'($urandom));
      step($sformatf("b2b_L%0d", i));
    end
    d = 4'($urandom);
    drive(1'b1, d); step("b2b_L5");
    drive(1'b0, 4'($urandom)); step("b2b_L6");
    chk("b2b_first_bit", {3'b0, tx}, {3'b0, d[0]});
    for (int i = 7; i <= 10; i++) begin
      drive(1'b0, 4'($urandom));
      step($sformatf("b2b_L%0d", i));
    end
    chk("b2b_finish_pulses", 4'(fin_seen - f0), 4'd2);

    // Random traffic with occasional loads and resets.
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 5) == 0, 4'($urandom));
      if ($urandom_range(0, 40) == 0) begin
        async_reset($sformatf("rnd_rst%0d", i));
        step($sformatf("rnd_rsth%0d", i));
        reset = 1'b1;
      end else begin
        step($sformatf("rnd%0d", i));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
